// File: rtl/io_initiator_pkg.sv
// Shared types and legal parameter ranges for the IO bus initiator.
// The bus and interrupt FSM encodings live here so both files agree on them.
package io_initiator_pkg;

  typedef enum logic [1:0] {
    B_IDLE,
    B_RDWAIT,
    B_RESP
  } bus_state_t;

  typedef enum logic [1:0] {
    I_IDLE,
    I_PEND,
    I_ACK,
    I_HOLD
  } int_state_t;

  localparam int RD_LATENCY_MIN  = 1;
  localparam int RD_LATENCY_MAX  = 4;
  localparam int ACK_HOLDOFF_MIN = 1;
  localparam int ACK_HOLDOFF_MAX = 7;

endpackage

// File: rtl/int_ack_ctrl.sv
// External-interrupt handshake: latch request/ID, present it to the core,
// pulse the acknowledge on take, then ignore the EIC for a hold-off window.
module int_ack_ctrl
  import io_initiator_pkg::*;
#(
  parameter int ACK_HOLDOFF = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic eic_int_req,
  input  logic eic_int_id,
  input  logic core_int_take,
  output logic core_int_pending,
  output logic core_int_id,
  output logic eic_int_ack
);

  localparam int HoldEff = (ACK_HOLDOFF < ACK_HOLDOFF_MIN) ? ACK_HOLDOFF_MIN :
                           (ACK_HOLDOFF > ACK_HOLDOFF_MAX) ? ACK_HOLDOFF_MAX : ACK_HOLDOFF;
  localparam int HoldCntW = $clog2(ACK_HOLDOFF_MAX + 1);
  localparam logic [HoldCntW-1:0] HoldInit = HoldCntW'(HoldEff);
  localparam logic [HoldCntW-1:0] HoldOne  = HoldCntW'(1);

  int_state_t            state_q, state_d;
  logic [HoldCntW-1:0]   hold_cnt_q, hold_cnt_d;
  logic                  pending_q, pending_d;
  logic                  id_q, id_d;
  logic                  ack_q, ack_d;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    pending_d  = pending_q;
    id_d       = id_q;
    ack_d      = 1'b0;
    case (state_q)
      I_IDLE: begin
        if (eic_int_req) begin
          id_d      = eic_int_id;
          pending_d = 1'b1;
          state_d   = I_PEND;
        end
      end
      I_PEND: begin
        if (core_int_take) begin
          pending_d = 1'b0;
          ack_d     = 1'b1;
          state_d   = I_ACK;
        end
      end
      I_ACK: begin
        hold_cnt_d = HoldInit;
        state_d    = I_HOLD;
      end
      I_HOLD: begin
        // Leave on the edge where the count reaches zero.
        if (hold_cnt_q <= HoldOne) begin
          hold_cnt_d = '0;
          state_d    = I_IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q - HoldOne;
        end
      end
      default: begin
        pending_d = 1'b0;
        state_d   = I_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= I_IDLE;
      hold_cnt_q <= '0;
      pending_q  <= 1'b0;
      id_q       <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      pending_q  <= pending_d;
      id_q       <= id_d;
      ack_q      <= ack_d;
    end
  end

  assign core_int_pending = pending_q;
  assign core_int_id      = id_q;
  assign eic_int_ack      = ack_q;

endmodule

// File: rtl/io_bus_initiator.sv
// Core-side initiator for the IO register bus plus the EIC interrupt handshake.
// Loads and stores are strobed for one cycle; loads return after a fixed latency.
module io_bus_initiator
  import io_initiator_pkg::*;
#(
  parameter int RD_LATENCY  = 1,
  parameter int ACK_HOLDOFF = 2
) (
  input  logic        Sys_Clock,
  input  logic        Sys_Reset,
  input  logic        Core_Req,
  input  logic        Core_Write,
  input  logic [29:0] Core_Address,
  input  logic [31:0] Core_WrData,
  output logic        Core_Ready,
  output logic        Core_RdValid,
  output logic [31:0] Core_RdData,
  output logic        Core_IntPending,
  output logic        Core_IntId,
  input  logic        Core_IntTake,
  output logic [29:0] Sys_Address,
  output logic [31:0] Sys_WrData,
  output logic        Sys_WrEn,
  output logic        Sys_RdEn,
  input  logic [31:0] Sys_RdData,
  input  logic        EIC_IntReq,
  input  logic        EIC_IntId,
  output logic        EIC_IntAck
);

  localparam int RdLatEff = (RD_LATENCY < RD_LATENCY_MIN) ? RD_LATENCY_MIN :
                            (RD_LATENCY > RD_LATENCY_MAX) ? RD_LATENCY_MAX : RD_LATENCY;
  localparam int RdCntW = $clog2(RD_LATENCY_MAX + 2);
  // The count spans the strobe cycle, the read latency, and the step into B_RESP.
  localparam logic [RdCntW-1:0] RdCntInit = RdCntW'(RdLatEff + 1);
  localparam logic [RdCntW-1:0] RdCntOne  = RdCntW'(1);

  bus_state_t          state_q, state_d;
  logic [RdCntW-1:0]   rd_cnt_q, rd_cnt_d;
  logic [29:0]         addr_q, addr_d;
  logic [31:0]         wr_data_q, wr_data_d;
  logic                wr_en_q, wr_en_d;
  logic                rd_en_q, rd_en_d;
  logic                rd_valid_q, rd_valid_d;
  logic [31:0]         rd_data_q, rd_data_d;
  logic [31:0]         rd_sample_q, rd_sample_d;
  logic                ready_q, ready_d;

  always_comb begin
    state_d     = state_q;
    rd_cnt_d    = rd_cnt_q;
    addr_d      = addr_q;
    wr_data_d   = wr_data_q;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    rd_valid_d  = 1'b0;
    rd_data_d   = rd_data_q;
    rd_sample_d = rd_sample_q;
    case (state_q)
      B_IDLE: begin
        if (Core_Req && ready_q) begin
          addr_d = Core_Address;
          if (Core_Write) begin
            wr_data_d = Core_WrData;
            wr_en_d   = 1'b1;
          end else begin
            rd_en_d  = 1'b1;
            rd_cnt_d = RdCntInit;
            state_d  = B_RDWAIT;
          end
        end
      end
      B_RDWAIT: begin
        if (rd_cnt_q == '0) begin
          rd_data_d  = rd_sample_q;
          rd_valid_d = 1'b1;
          state_d    = B_RESP;
        end else begin
          // Sys_RdData is captured RD_LATENCY edges after the strobe cycle ends.
          if (rd_cnt_q == RdCntOne) begin
            rd_sample_d = Sys_RdData;
          end
          rd_cnt_d = rd_cnt_q - RdCntOne;
        end
      end
      B_RESP: begin
        state_d = B_IDLE;
      end
      default: begin
        state_d = B_IDLE;
      end
    endcase
    ready_d = (state_d == B_IDLE);
  end

  always_ff @(posedge Sys_Clock or negedge Sys_Reset) begin
    if (!Sys_Reset) begin
      state_q     <= B_IDLE;
      rd_cnt_q    <= '0;
      addr_q      <= '0;
      wr_data_q   <= '0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      rd_sample_q <= '0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_cnt_q    <= rd_cnt_d;
      addr_q      <= addr_d;
      wr_data_q   <= wr_data_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      rd_sample_q <= rd_sample_d;
      ready_q     <= ready_d;
    end
  end

  assign Core_Ready   = ready_q;
  assign Core_RdValid = rd_valid_q;
  assign Core_RdData  = rd_data_q;
  assign Sys_Address  = addr_q;
  assign Sys_WrData   = wr_data_q;
  assign Sys_WrEn     = wr_en_q;
  assign Sys_RdEn     = rd_en_q;

  int_ack_ctrl #(
    .ACK_HOLDOFF(ACK_HOLDOFF)
  ) u_int_ack_ctrl (
    .clk             (Sys_Clock),
    .rst_n           (Sys_Reset),
    .eic_int_req     (EIC_IntReq),
    .eic_int_id      (EIC_IntId),
    .core_int_take   (Core_IntTake),
    .core_int_pending(Core_IntPending),
    .core_int_id     (Core_IntId),
    .eic_int_ack     (EIC_IntAck)
  );

endmodule

// File: tb/tb_io_bus_initiator.sv
// Directed, self-checking bench for io_bus_initiator with default parameters.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_io_bus_initiator;

  logic        Sys_Clock;
  logic        Sys_Reset;
  logic        Core_Req;
  logic        Core_Write;
  logic [29:0] Core_Address;
  logic [31:0] Core_WrData;
  logic        Core_Ready;
  logic        Core_RdValid;
  logic [31:0] Core_RdData;
  logic        Core_IntPending;
  logic        Core_IntId;
  logic        Core_IntTake;
  logic [29:0] Sys_Address;
  logic [31:0] Sys_WrData;
  logic        Sys_WrEn;
  logic        Sys_RdEn;
  logic [31:0] Sys_RdData;
  logic        EIC_IntReq;
  logic        EIC_IntId;
  logic        EIC_IntAck;

  logic [100:0] all_outs;
  int checks;
  int failures;

  assign all_outs = {Core_Ready, Core_RdValid, Core_RdData, Core_IntPending, Core_IntId,
                     Sys_Address, Sys_WrData, Sys_WrEn, Sys_RdEn, EIC_IntAck};

  io_bus_initiator dut (
    .Sys_Clock      (Sys_Clock),
    .Sys_Reset      (Sys_Reset),
    .Core_Req       (Core_Req),
    .Core_Write     (Core_Write),
    .Core_Address   (Core_Address),
    .Core_WrData    (Core_WrData),
    .Core_Ready     (Core_Ready),
    .Core_RdValid   (Core_RdValid),
    .Core_RdData    (Core_RdData),
    .Core_IntPending(Core_IntPending),
    .Core_IntId     (Core_IntId),
    .Core_IntTake   (Core_IntTake),
    .Sys_Address    (Sys_Address),
    .Sys_WrData     (Sys_WrData),
    .Sys_WrEn       (Sys_WrEn),
    .Sys_RdEn       (Sys_RdEn),
    .Sys_RdData     (Sys_RdData),
    .EIC_IntReq     (EIC_IntReq),
    .EIC_IntId      (EIC_IntId),
    .EIC_IntAck     (EIC_IntAck)
  );

  initial Sys_Clock = 1'b0;
  always #5 Sys_Clock = ~Sys_Clock;

  task automatic tick();
    @(posedge Sys_Clock);
    #1;
  endtask

  task automatic drive_req(input logic w, input logic [29:0] a, input logic [31:0] d);
    Core_Req     = 1'b1;
    Core_Write   = w;
    Core_Address = a;
    Core_WrData  = d;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++;
    if (all_outs !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got %h expected 0", all_outs);
    end
    Sys_Reset = 1'b1;
    tick();
    checks++;
    if (Core_Ready !== 1'b1 || Core_RdValid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_release: ready=%b rdvalid=%b expected ready=1 rdvalid=0",
               Core_Ready, Core_RdValid);
    end
  endtask

  task automatic test_store();
    drive_req(1'b1, 30'h0000010, 32'hDEADBEEF);
    tick();
    Core_Req = 1'b0;
    checks++;
    if (Sys_WrEn !== 1'b1 || Sys_RdEn !== 1'b0 || Sys_Address !== 30'h0000010 ||
        Sys_WrData !== 32'hDEADBEEF || Core_Ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL store_strobe: wren=%b rden=%b addr=%h data=%h ready=%b expected 1 0 0000010 deadbeef 1",
               Sys_WrEn, Sys_RdEn, Sys_Address, Sys_WrData, Core_Ready);
    end
    tick();
    checks++;
    if (Sys_WrEn !== 1'b0 || Sys_Address !== 30'h0000010 || Sys_WrData !== 32'hDEADBEEF) begin
      failures++;
      $display("[TB] FAIL store_hold: wren=%b addr=%h data=%h expected 0 0000010 deadbeef",
               Sys_WrEn, Sys_Address, Sys_WrData);
    end
  endtask

  task automatic test_load();
    Sys_RdData = 32'h12345678;
    drive_req(1'b0, 30'h0000020, 32'h0);
    tick();
    Core_Req = 1'b0;
    checks++;
    if (Sys_RdEn !== 1'b1 || Sys_WrEn !== 1'b0 || Sys_Address !== 30'h0000020 || Core_Ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL load_strobe: rden=%b wren=%b addr=%h ready=%b expected 1 0 0000020 0",
               Sys_RdEn, Sys_WrEn, Sys_Address, Core_Ready);
    end
    for (int i = 1; i <= 2; i++) begin
      tick();
      checks++;
      if (Sys_RdEn !== 1'b0 || Core_RdValid !== 1'b0 || Core_Ready !== 1'b0) begin
        failures++;
        $display("[TB] FAIL load_wait%0d: rden=%b rdvalid=%b ready=%b expected 0 0 0",
                 i, Sys_RdEn, Core_RdValid, Core_Ready);
      end
    end
    tick();
    Sys_RdData = 32'hBAD0BAD0;
    checks++;
    if (Core_RdValid !== 1'b1 || Core_RdData !== 32'h12345678 || Core_Ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL load_resp: rdvalid=%b data=%h ready=%b expected 1 12345678 0",
               Core_RdValid, Core_RdData, Core_Ready);
    end
    tick();
    checks++;
    if (Core_RdValid !== 1'b0 || Core_RdData !== 32'h12345678 || Core_Ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL load_after: rdvalid=%b data=%h ready=%b expected 0 12345678 1",
               Core_RdValid, Core_RdData, Core_Ready);
    end
  endtask

  task automatic test_back_to_back();
    logic        wr_tab [3];
    logic [29:0] addr_tab [3];
    logic [31:0] data_tab [3];
    int          acc_tick [3];
    int          idx;
    logic        ready_before;
    logic        req_before;
    wr_tab   = '{1'b1, 1'b0, 1'b1};
    addr_tab = '{30'h0000040, 30'h0000044, 30'h0000048};
    data_tab = '{32'hA5A50001, 32'h0, 32'hA5A50003};
    acc_tick = '{0, 0, 0};
    Sys_RdData = 32'hCAFE0001;
    idx = 0;
    drive_req(wr_tab[0], addr_tab[0], data_tab[0]);
    for (int t = 1; t <= 10; t++) begin
      ready_before = Core_Ready;
      req_before   = Core_Req;
      tick();
      if (req_before && ready_before) begin
        acc_tick[idx] = t;
        idx++;
        if (idx < 3) drive_req(wr_tab[idx], addr_tab[idx], data_tab[idx]);
        else Core_Req = 1'b0;
      end
      checks++;
      if (Sys_WrEn && Sys_RdEn) begin
        failures++;
        $display("[TB] FAIL b2b_exclusive t=%0d: wren=%b rden=%b expected not both", t, Sys_WrEn, Sys_RdEn);
      end
      checks++;
      if (Sys_WrEn !== (t == 1 || t == 7) || Sys_RdEn !== (t == 2) || Core_RdValid !== (t == 5)) begin
        failures++;
        $display("[TB] FAIL b2b_timing t=%0d: wren=%b rden=%b rdvalid=%b expected %b %b %b",
                 t, Sys_WrEn, Sys_RdEn, Core_RdValid, (t == 1 || t == 7), (t == 2), (t == 5));
      end
      if (t == 5) begin
        checks++;
        if (Core_RdData !== 32'hCAFE0001) begin
          failures++;
          $display("[TB] FAIL b2b_rddata: got %h expected cafe0001", Core_RdData);
        end
      end
      if (t == 7) begin
        checks++;
        if (Sys_Address !== 30'h0000048 || Sys_WrData !== 32'hA5A50003) begin
          failures++;
          $display("[TB] FAIL b2b_store2: addr=%h data=%h expected 0000048 a5a50003", Sys_Address, Sys_WrData);
        end
      end
    end
    checks++;
    if (acc_tick[0] != 1 || acc_tick[1] != 2 || acc_tick[2] != 7) begin
      failures++;
      $display("[TB] FAIL b2b_accept: ticks=%0d,%0d,%0d expected 1,2,7", acc_tick[0], acc_tick[1], acc_tick[2]);
    end
  endtask

  task automatic test_interrupt();
    Core_IntTake = 1'b1;
    tick();
    Core_IntTake = 1'b0;
    checks++;
    if (EIC_IntAck !== 1'b0 || Core_IntPending !== 1'b0) begin
      failures++;
      $display("[TB] FAIL int_stray_take: ack=%b pending=%b expected 0 0", EIC_IntAck, Core_IntPending);
    end
    EIC_IntReq = 1'b1;
    EIC_IntId  = 1'b1;
    tick();
    checks++;
    if (Core_IntPending !== 1'b1 || Core_IntId !== 1'b1 || EIC_IntAck !== 1'b0) begin
      failures++;
      $display("[TB] FAIL int_latch: pending=%b id=%b ack=%b expected 1 1 0", Core_IntPending, Core_IntId, EIC_IntAck);
    end
    Core_IntTake = 1'b1;
    tick();
    Core_IntTake = 1'b0;
    checks++;
    if (EIC_IntAck !== 1'b1 || Core_IntPending !== 1'b0) begin
      failures++;
      $display("[TB] FAIL int_ack: ack=%b pending=%b expected 1 0", EIC_IntAck, Core_IntPending);
    end
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (EIC_IntAck !== 1'b0 || Core_IntPending !== 1'b0) begin
        failures++;
        $display("[TB] FAIL int_holdoff%0d: ack=%b pending=%b expected 0 0", i, EIC_IntAck, Core_IntPending);
      end
    end
    tick();
    checks++;
    if (Core_IntPending !== 1'b1 || Core_IntId !== 1'b1) begin
      failures++;
      $display("[TB] FAIL int_relatch: pending=%b id=%b expected 1 1", Core_IntPending, Core_IntId);
    end
    Core_IntTake = 1'b1;
    EIC_IntReq   = 1'b0;
    tick();
    Core_IntTake = 1'b0;
    checks++;
    if (EIC_IntAck !== 1'b1) begin
      failures++;
      $display("[TB] FAIL int_ack2: ack=%b expected 1", EIC_IntAck);
    end
    repeat (5) tick();
  endtask

  task automatic test_int_withdraw();
    EIC_IntReq = 1'b1;
    EIC_IntId  = 1'b0;
    tick();
    checks++;
    if (Core_IntPending !== 1'b1 || Core_IntId !== 1'b0) begin
      failures++;
      $display("[TB] FAIL withdraw_latch: pending=%b id=%b expected 1 0", Core_IntPending, Core_IntId);
    end
    EIC_IntReq = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      EIC_IntId = ~EIC_IntId;
      tick();
      checks++;
      if (Core_IntPending !== 1'b1 || Core_IntId !== 1'b0 || EIC_IntAck !== 1'b0) begin
        failures++;
        $display("[TB] FAIL withdraw_hold%0d: pending=%b id=%b ack=%b expected 1 0 0",
                 i, Core_IntPending, Core_IntId, EIC_IntAck);
      end
    end
    Core_IntTake = 1'b1;
    tick();
    Core_IntTake = 1'b0;
    checks++;
    if (EIC_IntAck !== 1'b1 || Core_IntPending !== 1'b0 || Core_IntId !== 1'b0) begin
      failures++;
      $display("[TB] FAIL withdraw_take: ack=%b pending=%b id=%b expected 1 0 0",
               EIC_IntAck, Core_IntPending, Core_IntId);
    end
    repeat (5) tick();
  endtask

  task automatic test_reset_mid_load();
    EIC_IntReq = 1'b1;
    EIC_IntId  = 1'b1;
    Sys_RdData = 32'h0BADF00D;
    drive_req(1'b0, 30'h0000060, 32'h0);
    tick();
    Core_Req   = 1'b0;
    EIC_IntReq = 1'b0;
    tick();
    Sys_Reset = 1'b0;
    #1;
    checks++;
    if (all_outs !== '0) begin
      failures++;
      $display("[TB] FAIL midload_reset: got %h expected 0", all_outs);
    end
    repeat (2) tick();
    Sys_Reset = 1'b1;
    tick();
    checks++;
    if (Core_Ready !== 1'b1 || Core_IntPending !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midload_release: ready=%b pending=%b expected 1 0", Core_Ready, Core_IntPending);
    end
    drive_req(1'b1, 30'h0000080, 32'h55AA55AA);
    tick();
    Core_Req = 1'b0;
    checks++;
    if (Sys_WrEn !== 1'b1 || Sys_Address !== 30'h0000080 || Sys_WrData !== 32'h55AA55AA) begin
      failures++;
      $display("[TB] FAIL midload_store: wren=%b addr=%h data=%h expected 1 0000080 55aa55aa",
               Sys_WrEn, Sys_Address, Sys_WrData);
    end
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if (Core_RdValid !== 1'b0 || Core_RdData !== 32'h0) begin
        failures++;
        $display("[TB] FAIL midload_stale%0d: rdvalid=%b data=%h expected 0 0", i, Core_RdValid, Core_RdData);
      end
    end
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    Sys_Reset    = 1'b0;
    Core_Req     = 1'b0;
    Core_Write   = 1'b0;
    Core_Address = '0;
    Core_WrData  = '0;
    Core_IntTake = 1'b0;
    Sys_RdData   = '0;
    EIC_IntReq   = 1'b0;
    EIC_IntId    = 1'b0;
    test_reset();
    test_store();
    test_load();
    test_back_to_back();
    test_interrupt();
    test_int_withdraw();
    test_reset_mid_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
